// File: rtl/uart_pkg.sv
// Shared UART constants: frame shape, FSM state encoding and the baud divisor table.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned STOP_BITS    = 1;
    localparam int unsigned DIV_W        = 16;
    localparam int unsigned BAUD_SEL_W   = 3;
    localparam int unsigned BIT_IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Line rate in bit/s for each Baud_set code.
    function automatic int unsigned baud_rate(input logic [BAUD_SEL_W-1:0] sel);
        int unsigned rate;
        case (sel)
            3'd0:    rate = 115_200;
            3'd1:    rate = 57_600;
            3'd2:    rate = 38_400;
            3'd3:    rate = 19_200;
            3'd4:    rate = 9_600;
            3'd5:    rate = 4_800;
            3'd6:    rate = 2_400;
            default: rate = 1_200;
        endcase
        return rate;
    endfunction

    // Clocks per bit, rounded to nearest; only evaluated as an elaboration constant.
    function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                  input logic [BAUD_SEL_W-1:0] sel);
        int unsigned rate;
        rate = baud_rate(sel);
        return DIV_W'((clk_freq + (rate / 2)) / rate);
    endfunction

endpackage

// File: rtl/uart_send_if.sv
// Byte-request / serial-line bundle between a byte producer and the transmitter.
interface uart_send_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0]  Data;
    logic [BAUD_SEL_W-1:0] Baud_set;
    logic                  send_en;
    logic                  uart_tx;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        output Data, Baud_set, send_en,
        input  uart_tx, tx_busy, tx_done
    );

    modport slave (
        input  Data, Baud_set, send_en,
        output uart_tx, tx_busy, tx_done
    );

endinterface

// File: rtl/uart_baud_sel.sv
// Combinational Baud_set -> clocks-per-bit lookup, shared with the receiver.
module uart_baud_sel
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ
) (
    input  logic [BAUD_SEL_W-1:0] Baud_set,
    output logic [DIV_W-1:0]      div_c
);

    localparam logic [DIV_W-1:0] DIV_0 = baud_div(CLK_FREQ, 3'd0);
    localparam logic [DIV_W-1:0] DIV_1 = baud_div(CLK_FREQ, 3'd1);
    localparam logic [DIV_W-1:0] DIV_2 = baud_div(CLK_FREQ, 3'd2);
    localparam logic [DIV_W-1:0] DIV_3 = baud_div(CLK_FREQ, 3'd3);
    localparam logic [DIV_W-1:0] DIV_4 = baud_div(CLK_FREQ, 3'd4);
    localparam logic [DIV_W-1:0] DIV_5 = baud_div(CLK_FREQ, 3'd5);
    localparam logic [DIV_W-1:0] DIV_6 = baud_div(CLK_FREQ, 3'd6);
    localparam logic [DIV_W-1:0] DIV_7 = baud_div(CLK_FREQ, 3'd7);

    // Constant table mux; no runtime division.
    always_comb begin
        div_c = DIV_0;
        case (Baud_set)
            3'd0:    div_c = DIV_0;
            3'd1:    div_c = DIV_1;
            3'd2:    div_c = DIV_2;
            3'd3:    div_c = DIV_3;
            3'd4:    div_c = DIV_4;
            3'd5:    div_c = DIV_5;
            3'd6:    div_c = DIV_6;
            default: div_c = DIV_7;
        endcase
    end

endmodule

// File: rtl/uart_send.sv
// 8N1 UART transmitter: one byte per accepted request, LSB first, registered line.
module uart_send
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ
) (
    input  logic        sysclk,
    input  logic        rst,
    uart_send_if.slave  tx_if
);

    logic [DIV_W-1:0]     div_sel_c;
    uart_state_t          state;
    logic [DIV_W-1:0]     baud_cnt;
    logic [DIV_W-1:0]     div_q;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 uart_tx;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 bit_end_c;
    logic                 accept_c;

    uart_baud_sel #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud_sel (
        .Baud_set (tx_if.Baud_set),
        .div_c    (div_sel_c)
    );

    // Last clock of the current bit period.
    assign bit_end_c = (baud_cnt == (div_q - DIV_W'(1)));

    // A request is taken in IDLE, or on the stop bit's last clock so frames can abut.
    assign accept_c = tx_if.send_en &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_end_c));

    // Frame sequencer: state, bit timing, shift data and registered line outputs.
    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            div_q    <= '0;
            bit_idx  <= '0;
            data_q   <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= (state == ST_STOP) && bit_end_c;
            if (accept_c) begin
                state    <= ST_START;
                data_q   <= tx_if.Data;
                div_q    <= div_sel_c;
                baud_cnt <= '0;
                bit_idx  <= '0;
                uart_tx  <= 1'b0;
                tx_busy  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        uart_tx <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    ST_START: begin
                        if (bit_end_c) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            uart_tx  <= data_q[0];
                            state    <= ST_DATA;
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end
                    ST_DATA: begin
                        if (bit_end_c) begin
                            baud_cnt <= '0;
                            if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                                uart_tx <= 1'b1;
                                state   <= ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + BIT_IDX_W'(1);
                                uart_tx <= data_q[bit_idx + BIT_IDX_W'(1)];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end
                    ST_STOP: begin
                        if (bit_end_c) begin
                            baud_cnt <= '0;
                            uart_tx  <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        uart_tx <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_if.uart_tx = uart_tx;
    assign tx_if.tx_busy = tx_busy;
    assign tx_if.tx_done = tx_done;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: frame-level reference model, loopback receiver, literal pins.
module tb_uart_send;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    uart_send_if tx_if ();

    uart_send #(
        .CLK_FREQ (50_000_000)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .tx_if  (tx_if)
    );

    always #10 sysclk = ~sysclk;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned done_cnt = 0;
    int unsigned done_win = 0;
    int unsigned rx_cnt   = 0;
    int unsigned exp_cnt  = 0;
    bit          rx_en    = 1'b0;
    logic [7:0]  exp_rx[$];

    // Clocks per bit for each rate code, from the rate table.
    function automatic int unsigned div_tab(input logic [2:0] sel);
        int unsigned t [8];
        t = '{434, 868, 1302, 2604, 5208, 10417, 20833, 41667};
        return t[sel];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Input capture at each active edge.
    logic       s_send = 1'b0;
    logic       s_rst  = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic [2:0] s_baud = 3'd0;
    always @(posedge sysclk) begin
        cyc    <= cyc + 1;
        s_send <= tx_if.send_en;
        s_data <= tx_if.Data;
        s_baud <= tx_if.Baud_set;
        s_rst  <= rst;
    end

    // Frame-level model: a frame is (start cycle, byte, divisor); line follows from elapsed time.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int unsigned m_start  = 0;
    int unsigned m_div    = 434;
    logic [7:0]  m_byte   = 8'h00;
    bit          exp_tx;
    bit          exp_busy;
    int unsigned e;
    int unsigned b;

    always @(negedge sysclk) begin
        m_done = 1'b0;
        if (!rst || !s_rst) begin
            m_active = 1'b0;
        end else begin
            if (m_active && ((cyc - m_start) == 10 * m_div)) begin
                m_done   = 1'b1;
                m_active = 1'b0;
            end
            if (!m_active && s_send) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_byte   = s_data;
                m_div    = div_tab(s_baud);
            end
        end
        if (m_active) begin
            e        = cyc - m_start;
            b        = e / m_div;
            exp_busy = 1'b1;
            if (b == 0)      exp_tx = 1'b0;
            else if (b <= 8) exp_tx = m_byte[3'(b - 1)];
            else             exp_tx = 1'b1;
        end else begin
            exp_busy = 1'b0;
            exp_tx   = 1'b1;
        end
        check("line", tx_if.uart_tx, exp_tx);
        check("busy", tx_if.tx_busy, exp_busy);
        check("done", tx_if.tx_done, m_done);
        if (tx_if.tx_done === 1'b1) begin
            done_cnt++;
            if (rx_en) done_win++;
        end
    end

    // Loopback receiver: centre-samples the line with the divisor of the accepted request.
    int unsigned rx_d;
    logic [7:0]  rx_b;
    logic        rx_start;
    initial begin : rx_proc
        forever begin
            @(negedge sysclk);
            if (rx_en && rst && tx_if.uart_tx === 1'b0) begin
                rx_d = div_tab(s_baud);
                repeat (rx_d / 2) @(negedge sysclk);
                rx_start = tx_if.uart_tx;
                for (int k = 0; k < 8; k++) begin
                    repeat (rx_d) @(negedge sysclk);
                    rx_b[k] = tx_if.uart_tx;
                end
                repeat (rx_d) @(negedge sysclk);
                check("rx_start_bit", rx_start, 1'b0);
                check("rx_stop_bit", tx_if.uart_tx, 1'b1);
                rx_cnt++;
                if (exp_rx.size() != 0) check("rx_byte", rx_b, exp_rx.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge sysclk);
    endtask

    // Raise send_en for one accepted edge; returns the acceptance edge index.
    task automatic send(input logic [7:0] d, input logic [2:0] bs, input bit hold,
                        output int unsigned e0);
        @(negedge sysclk);
        tx_if.Data     = d;
        tx_if.Baud_set = bs;
        tx_if.send_en  = 1'b1;
        @(negedge sysclk);
        e0 = cyc;
        if (!hold) tx_if.send_en = 1'b0;
    endtask

    initial begin : watchdog
        #2400000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    int unsigned e0;
    int unsigned t;
    int unsigned d0;
    logic [9:0]  pat;
    logic [7:0]  rbyte;

    initial begin : stim
        tx_if.Data     = 8'h00;
        tx_if.Baud_set = 3'd0;
        tx_if.send_en  = 1'b1;
        #1 rst = 1'b0;

        // Reset held with a pending request.
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            check("rst_line", tx_if.uart_tx, 1'b1);
            check("rst_busy", tx_if.tx_busy, 1'b0);
            check("rst_done", tx_if.tx_done, 1'b0);
        end
        tx_if.send_en = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge sysclk);
        check("post_rst_busy", tx_if.tx_busy, 1'b0);
        check("post_rst_line", tx_if.uart_tx, 1'b1);

        // Back-to-back 0xAB then 0xCD with send_en held through tx_done.
        rx_en = 1'b1;
        exp_rx.push_back(8'hAB);
        exp_rx.push_back(8'hCD);
        exp_cnt += 2;
        d0 = done_cnt;
        send(8'hAB, 3'd0, 1'b1, e0);
        tx_if.Data = 8'hCD;
        pat = {1'b1, 8'hAB, 1'b0};
        for (int k = 0; k < 10; k++) begin
            wait_cyc(e0 + 217 + 434 * k);
            check("ab_bit_centre", tx_if.uart_tx, pat[k]);
        end
        wait_cyc(e0 + 4339);
        check("ab_done_early", tx_if.tx_done, 1'b0);
        wait_cyc(e0 + 4340);
        check("ab_done", tx_if.tx_done, 1'b1);
        check("b2b_start_line", tx_if.uart_tx, 1'b0);
        check("b2b_busy", tx_if.tx_busy, 1'b1);
        tx_if.send_en = 1'b0;
        wait_cyc(e0 + 8680);
        check("cd_done", tx_if.tx_done, 1'b1);
        wait_cyc(e0 + 8682);
        check("b2b_idle_busy", tx_if.tx_busy, 1'b0);
        check("b2b_pulses", done_cnt - d0, 2);

        // 0xFF frame: rejected requests and a mid-frame rate change.
        exp_rx.push_back(8'hFF);
        exp_cnt += 1;
        d0 = done_cnt;
        send(8'hFF, 3'd0, 1'b0, e0);
        wait_cyc(e0 + 433);
        check("ff_start_end", tx_if.uart_tx, 1'b0);
        wait_cyc(e0 + 434);
        check("ff_bit0_begin", tx_if.uart_tx, 1'b1);
        wait_cyc(e0 + 1000);
        tx_if.Data     = 8'h00;
        tx_if.Baud_set = 3'd7;
        tx_if.send_en  = 1'b1;
        @(negedge sysclk);
        tx_if.send_en  = 1'b0;
        t = e0 + 1100;
        repeat (6) begin
            t += $urandom_range(100, 400);
            wait_cyc(t);
            tx_if.Data    = 8'($urandom);
            tx_if.send_en = 1'b1;
            @(negedge sysclk);
            tx_if.send_en = 1'b0;
        end
        wait_cyc(e0 + 217 + 434 * 8);
        check("ff_bit7", tx_if.uart_tx, 1'b1);
        wait_cyc(e0 + 434 * 9 + 217);
        check("ff_stop_busy", tx_if.tx_busy, 1'b1);
        wait_cyc(e0 + 4340);
        check("ff_done", tx_if.tx_done, 1'b1);
        check("ff_done_busy", tx_if.tx_busy, 1'b0);
        wait_cyc(e0 + 4345);
        check("ff_one_frame", done_cnt - d0, 1);

        // Rate 4: 0x55, 5208 clocks per bit.
        exp_rx.push_back(8'h55);
        exp_cnt += 1;
        send(8'h55, 3'd4, 1'b0, e0);
        wait_cyc(e0 + 5207);
        check("r4_start_end", tx_if.uart_tx, 1'b0);
        wait_cyc(e0 + 5208);
        check("r4_bit0", tx_if.uart_tx, 1'b1);
        wait_cyc(e0 + 10415);
        check("r4_bit0_end", tx_if.uart_tx, 1'b1);
        wait_cyc(e0 + 10416);
        check("r4_bit1", tx_if.uart_tx, 1'b0);
        wait_cyc(e0 + 52079);
        check("r4_done_early", tx_if.tx_done, 1'b0);
        wait_cyc(e0 + 52080);
        check("r4_done", tx_if.tx_done, 1'b1);
        wait_cyc(e0 + 52083);

        // Loopback at rates 1 and 0.
        exp_rx.push_back(8'hA5);
        exp_cnt += 1;
        send(8'hA5, 3'd1, 1'b0, e0);
        wait_cyc(e0 + 8680);
        check("r1_done", tx_if.tx_done, 1'b1);
        wait_cyc(e0 + 8683);
        exp_rx.push_back(8'h00);
        exp_cnt += 1;
        send(8'h00, 3'd0, 1'b0, e0);
        wait_cyc(e0 + 4343);
        rx_en = 1'b0;

        // Reset mid-frame on a random byte at rate 2.
        d0 = done_cnt;
        rbyte = 8'($urandom);
        send(rbyte, 3'd2, 1'b0, e0);
        wait_cyc(e0 + 2000);
        #5 rst = 1'b0;
        #1;
        check("abort_line", tx_if.uart_tx, 1'b1);
        check("abort_busy", tx_if.tx_busy, 1'b0);
        check("abort_done", tx_if.tx_done, 1'b0);
        repeat (3) @(negedge sysclk);
        rst = 1'b1;
        repeat (50) @(negedge sysclk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", tx_if.tx_busy, 1'b0);

        check("rx_count", rx_cnt, exp_cnt);
        check("rx_per_done", rx_cnt, done_win);
        check("rx_leftover", exp_rx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
